logic_unit_seq: RTL and testbench

//  Parametrised, slice-serial bitwise logic unit for the ALU datapath. Covers
//  NOT/NAND/AND/OR/XOR/XNOR/NOR/PASS on WIDTH-bit operands, SLICE bits per cycle.

---
 rtl/logic_unit_seq.sv | 105 ++++++++++
 tb/tb_logic_unit_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: WIDTH-bit NOT/NAND/AND/OR/XOR/XNOR/NOR/PASS,
// SLICE bits per cycle, valid/ready on both sides, zero and parity flags.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDXW-1:0]   idx;
  logic              accept, last;
  logic [SLICE-1:0]  sa, sb, res;

  assign in_ready  = reset_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDXW'(NSLICE - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand slice for the current index, then the selected bitwise op on it.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx == IDXW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    res = '0;
    case (op_q)
      3'b000:  res = ~sa;
      3'b001:  res = ~(sa & sb);
      3'b010:  res = sa & sb;
      3'b011:  res = sa | sb;
      3'b100:  res = sa ^ sb;
      3'b101:  res = ~(sa ^ sb);
      3'b110:  res = ~(sa | sb);
      default: res = sa;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      y      <= '0;
      zero   <= 1'b0;
      parity <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op;
        a_q    <= a;
        b_q    <= b;
        idx    <= '0;
        zero   <= 1'b1;
        parity <= 1'b0;
      end else if (state == BUSY) begin
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (idx == IDXW'(i)) y[i*SLICE +: SLICE] <= res;
        end
        zero   <= zero & (res == '0);
        parity <= parity ^ (^res);
        if (!last) idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: a 32/8 instance and a 16/16 instance,
// hand-computed results, flags, latency, reset drop, backpressure and back-to-back.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
  logic [2:0]  op;
  logic [31:0] a, b, y;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, parity16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, y16;

  int checks   = 0;
  int failures = 0;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity)
  );

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .y(y16), .zero(zero16), .parity(parity16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    op = 3'b111;
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      tick;
      cnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [2:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] ey, input logic ez,
                         input logic ep);
    start_op(tag, o, aa, bb);
    wait_done(tag, 4);
    check({tag, "_y"}, y, ey);
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_parity"}, 32'(parity), 32'(ep));
    drain(tag);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  o;
    logic [31:0] va, vb, ey;
    logic        ez, ep;
  } vec_t;

  vec_t vecs[7] = '{
    '{"not",  3'b000, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b0},
    '{"nand", 3'b001, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FFFF, 1'b0, 1'b0},
    '{"or",   3'b011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b1},
    '{"xor",  3'b100, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001, 1'b0, 1'b1},
    '{"xnor", 3'b101, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0},
    '{"nor",  3'b110, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0},
    '{"pass", 3'b111, 32'h0102_0304, 32'hFFFF_FFFF, 32'h0102_0304, 1'b0, 1'b1}
  };

  initial begin
    int cnt;
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    tick;
    tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready_rel", 32'(in_ready), 32'd1);

    // Reset mid-BUSY drops the op
    start_op("rbusy", 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF);
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    check("rbusy_in_ready", 32'(in_ready), 32'd0);
    check("rbusy_valid1", 32'(out_valid), 32'd0);
    tick;
    check("rbusy_y", y, 32'd0);
    check("rbusy_valid2", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rbusy_in_ready_rel", 32'(in_ready), 32'd1);
    repeat (6) tick;
    check("rbusy_dropped", 32'(out_valid), 32'd0);

    run_vec("and", 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b1);

    // XOR to zero, then held in DONE under backpressure with a pending request
    start_op("xz", 3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_done("xz", 4);
    check("xz_y", y, 32'd0);
    check("xz_zero", 32'(zero), 32'd1);
    check("xz_parity", 32'(parity), 32'd0);
    in_valid = 1'b1; op = 3'b000; a = 32'd0; b = 32'h1357_9BDF; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_y", y, 32'd0);
      check("bp_zero", 32'(zero), 32'd1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick;
    check("b2b_valid", 32'(out_valid), 32'd0);
    check("b2b_no_idle", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0; a = 32'hFFFF_FFFF;
    wait_done("b2b", 4);
    check("b2b_y", y, 32'hFFFF_FFFF);
    check("b2b_zero", 32'(zero), 32'd0);
    check("b2b_parity", 32'(parity), 32'd0);
    drain("b2b");

    foreach (vecs[i])
      run_vec(vecs[i].tag, vecs[i].o, vecs[i].va, vecs[i].vb, vecs[i].ey, vecs[i].ez, vecs[i].ep);

    // Single-slice configuration: latency 1
    in_valid16 = 1'b1; op16 = 3'b101; a16 = 16'h00FF; b16 = 16'h0F0F;
    #1;
    check("w16_in_ready", 32'(in_ready16), 32'd1);
    tick;
    in_valid16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h3C3C; op16 = 3'b000;
    cnt = 0;
    while (out_valid16 !== 1'b1 && cnt < 20) begin
      tick;
      cnt++;
    end
    check("w16_lat", 32'(cnt), 32'd1);
    check("w16_y", 32'(y16), 32'h0000_F00F);
    check("w16_zero", 32'(zero16), 32'd0);
    check("w16_parity", 32'(parity16), 32'd0);
    out_ready16 = 1'b1;
    tick;
    out_ready16 = 1'b0;
    check("w16_drain", 32'(out_valid16), 32'd0);

    in_valid16 = 1'b1; op16 = 3'b010; a16 = 16'hF0F0; b16 = 16'h0F0F;
    tick;
    in_valid16 = 1'b0;
    cnt = 0;
    while (out_valid16 !== 1'b1 && cnt < 20) begin
      tick;
      cnt++;
    end
    check("w16z_lat", 32'(cnt), 32'd1);
    check("w16z_y", 32'(y16), 32'd0);
    check("w16z_zero", 32'(zero16), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
